mem_port_arbiter: RTL

//  Shares the single unified instruction/data memory between the multi-cycle CPU

---
 rtl/mem_port_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Serialises CPU and debug/loader accesses onto one unified memory port with a
// fixed-latency req/ack handshake. Define MEM_ARB_RR_EN for round-robin ties (default: CPU priority).
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic P_CPU = 1'b0;
  localparam logic P_DBG = 1'b1;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic          r_grant;
  logic          r_mem_en;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_cpu_ack;
  logic          r_dbg_ack;
  logic [DW-1:0] r_cpu_rdata;
  logic [DW-1:0] r_dbg_rdata;
  logic          w_win;
  logic          w_grant_en;
  logic          w_last_beat;

`ifdef MEM_ARB_RR_EN
  logic r_last_grant;

  // Round-robin: on a tie the port that did not win last time is chosen.
  always_comb begin
    w_win = P_CPU;
    if (cpu_req && dbg_req) begin
      w_win = ~r_last_grant;
    end else if (cpu_req) begin
      w_win = P_CPU;
    end else begin
      w_win = P_DBG;
    end
  end

  // Remember the most recent grant; reset to DBG so the CPU wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= P_DBG;
    end else if (w_grant_en) begin
      r_last_grant <= w_win;
    end else begin
      r_last_grant <= r_last_grant;
    end
  end
`else
  // Fixed priority: debug only wins when the CPU is not asking.
  always_comb begin
    w_win = P_CPU;
    if (cpu_req) begin
      w_win = P_CPU;
    end else begin
      w_win = P_DBG;
    end
  end
`endif

  // Next-state logic for the IDLE -> BUSY -> RESP sequence.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_en  = 1'b0;
    w_last_beat = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cpu_req || dbg_req) begin
          w_state_nxt = ST_BUSY;
          w_grant_en  = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (r_cnt == CNT_ZERO) begin
          w_state_nxt = ST_RESP;
          w_last_beat = 1'b1;
        end else begin
          w_state_nxt = ST_BUSY;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Memory-side request registers: latched at grant, held for the whole access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant     <= P_CPU;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cnt       <= CNT_ZERO;
    end else if (w_grant_en) begin
      r_grant     <= w_win;
      r_mem_en    <= 1'b1;
      r_mem_we    <= (w_win == P_DBG) ? dbg_we : cpu_we;
      r_mem_addr  <= (w_win == P_DBG) ? dbg_addr : cpu_addr;
      r_mem_wdata <= (w_win == P_DBG) ? dbg_wdata : cpu_wdata;
      r_cnt       <= CNT_LOAD;
    end else if (w_last_beat) begin
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
    end else if (r_state == ST_BUSY) begin
      r_cnt <= r_cnt - CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Ack pulses for the RESP cycle, and read-data capture on the last BUSY edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cpu_ack   <= 1'b0;
      r_dbg_ack   <= 1'b0;
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
    end else begin
      r_cpu_ack <= w_last_beat && (r_grant == P_CPU);
      r_dbg_ack <= w_last_beat && (r_grant == P_DBG);
      if (w_last_beat && !r_mem_we && (r_grant == P_CPU)) begin
        r_cpu_rdata <= mem_rdata;
      end else begin
        r_cpu_rdata <= r_cpu_rdata;
      end
      if (w_last_beat && !r_mem_we && (r_grant == P_DBG)) begin
        r_dbg_rdata <= mem_rdata;
      end else begin
        r_dbg_rdata <= r_dbg_rdata;
      end
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_ack   = r_cpu_ack;
  assign dbg_ack   = r_dbg_ack;
  assign cpu_rdata = r_cpu_rdata;
  assign dbg_rdata = r_dbg_rdata;
  assign cpu_stall = cpu_req & ~r_cpu_ack;

endmodule
